fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//   Upstream sequencer for the 8-bit ALU/result-store stage (instruction_memory).
//   Holds a small program memory, a PC and a 4x8 register file. Runs a 4-phase FSM
//   that fetches each 16-bit instruction and drives the downstream a/b/opcode/save inputs.
//   Writes the returned alu_out/carry_out back into the register file.
// PARAMETERS
//   PROG_DEPTH  16  number of program words; must be a power of 2
//   PC_W        4   PC width = log2(PROG_DEPTH)
// PORTS
//   clk        in   1     single clock, rising edge
//   reset      in   1     synchronous, active-high
//   start      in   1     begin execution at PC 0 (sampled in IDLE only)
//   prog_we    in   1     program-memory write strobe (honoured in IDLE/HALT only)
//   prog_addr  in   PC_W  program write address
//   prog_data  in   16    program word
//   rf_we      in   1     register preload strobe (honoured in IDLE/HALT only)
//   rf_addr    in   2     preload register index
//   rf_data    in   8     preload value
//   alu_out    in   8     result from downstream stage
//   carry_out  in   1     carry from downstream stage
//   a          out  8     operand A to downstream
//   b          out  8     operand B to downstream
//   opcode     out  3     ALU select to downstream
//   save       out  1     1-cycle store strobe to downstream
//   pc         out  PC_W  address of the current instruction
//   carry_flag out  1     carry latched at the last writeback
//   busy       out  1     high in FETCH/DECODE/EXEC/WB
//   halted     out  1     high in HALT
// BEHAVIOUR
//   Instruction word: [15:13] opcode, [12:11] rd, [10:9] rs1, [8:7] rs2, [6] st (drive save),
//     [5:0] reserved (ignored). 16'hFFFF = HALT. Opcodes 000..111 =
//     add, sub, and, or, xor, mul, div, comp.
//   Reset: state=IDLE; pc=0; regs=0; a=b=0; opcode=0; save=0; carry_flag=0; busy=0; halted=0.
//     Program memory is NOT cleared. Reset in any state aborts the instruction with no writeback.
//   FSM: IDLE -start-> FETCH -> DECODE -> EXEC -> WB -> FETCH | HALT.
//     FETCH: IR <= prog[pc].
//     DECODE: IR==FFFF -> HALT (pc unchanged); else a<=R[rs1], b<=R[rs2], opcode<=IR[15:13].
//     EXEC: a/b/opcode held stable; save=IR[6] for exactly this cycle.
//     WB: R[rd]<=alu_out, carry_flag<=carry_out; pc<=pc+1, wrapping PC_W-1 ones -> 0.
//     HALT: outputs hold; start -> pc=0, goto FETCH.
//   Latency: 4 cycles/instruction. alu_out must be valid by the end of EXEC (comb ALU).
//   Register result is visible to the next instruction's DECODE (no hazard, no bypass needed).
//   rs1==rs2 and rd==rs1 are legal; the old value is read and the new value is written at WB.
//   prog_we/rf_we while busy: ignored (no write). start while busy: ignored.
//   Simultaneous rf_we and start in IDLE: the preload write happens and FETCH is entered;
//     the written value is visible at DECODE.
//   save is 0 in every state except EXEC.
// STRUCTURE
//   cpu8_pkg: opcode localparams (OP_ADD..OP_COMP), state encoding, instruction field
//     positions, HALT_WORD=16'hFFFF.
//   Sub-module fdu_regfile: 4x8, 2 comb read ports, 1 sync write port muxed
//     between preload and WB, sync reset to 0.
//   Program memory is an inferred reg array, written synchronously with no reset.
// TESTING
//   Reset mid-EXEC of ADD -> next cycle IDLE, save=0, pc=0, rd unchanged (0).
//   Preload R1=5, R2=3; prog[0]=ADD rd=R0 rs1=R1 rs2=R2 st=1, prog[1]=FFFF; start ->
//     EXEC at cycle 3 shows a=5, b=3, opcode=000, save=1; with alu_out=8, R0=8 after WB;
//     halted=1, pc=1.
//   Chain: prog[0]: R3=R1 sub R2; prog[1]: R3=R3 xor R1, using a bench ALU model ->
//     2nd instruction sees a=2 (R3=2), then R3=7.
//   PROG_DEPTH=16, no HALT word in memory -> pc goes 15 -> 0 after WB, execution continues.
//   prog_we/rf_we pulses while busy -> memory and registers unchanged; start in HALT
//     -> restart from pc=0.
//   carry_out=1 at WB of MUL 200*2 -> carry_flag=1; the next instruction with carry_out=0
//     -> carry_flag=0.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared definitions for the fetch/decode sequencer: opcodes, FSM states,
// instruction field positions and the HALT encoding.
package cpu8_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_COMP = 3'd7;

    localparam int NUM_REGS = 4;
    localparam int REG_W    = 8;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int RD_HI  = 12;
    localparam int RD_LO  = 11;
    localparam int RS1_HI = 10;
    localparam int RS1_LO = 9;
    localparam int RS2_HI = 8;
    localparam int RS2_LO = 7;
    localparam int ST_BIT = 6;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Operand/result bus between the sequencer and the downstream ALU stage.
// The sequencer is the master: it drives operands, opcode and the store strobe
// and receives the combinational ALU result and carry.
interface fetch_decode_unit_if;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opcode;
    logic       save;
    logic [7:0] alu_out;
    logic       carry_out;

    modport master (
        output a, b, opcode, save,
        input  alu_out, carry_out
    );

    modport slave (
        input  a, b, opcode, save,
        output alu_out, carry_out
    );
endinterface

// File: rtl/fdu_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
// The write port is shared between host preload and instruction writeback.
module fdu_regfile
    import cpu8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       wr_addr,
    input  logic [REG_W-1:0] wr_data,
    input  logic [1:0]       rd_addr1,
    input  logic [1:0]       rd_addr2,
    output logic [REG_W-1:0] rd_data1,
    output logic [REG_W-1:0] rd_data2
);

    logic [REG_W-1:0] regs [NUM_REGS];

    // Clear all registers on reset, otherwise perform the single selected write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/fetch_decode_unit.sv
// Sequencer for the 8-bit ALU stage: program memory, PC, register file and a
// FETCH/DECODE/EXEC/WB loop that feeds operands downstream and writes back
// the returned result and carry.
module fetch_decode_unit
    import cpu8_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 prog_we,
    input  logic [PC_W-1:0]      prog_addr,
    input  logic [15:0]          prog_data,
    input  logic                 rf_we,
    input  logic [1:0]           rf_addr,
    input  logic [7:0]           rf_data,
    fetch_decode_unit_if.master  alu,
    output logic [PC_W-1:0]      pc,
    output logic                 carry_flag,
    output logic                 busy,
    output logic                 halted
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    logic [15:0] prog [PROG_DEPTH];

    logic        idle_or_halt;
    logic [7:0]  rs1_val;
    logic [7:0]  rs2_val;
    logic        rf_wr_en;
    logic [1:0]  rf_wr_addr;
    logic [7:0]  rf_wr_data;

    assign idle_or_halt = (state == ST_IDLE) || (state == ST_HALT);
    assign busy         = (state == ST_FETCH) || (state == ST_DECODE) ||
                          (state == ST_EXEC)  || (state == ST_WB);
    assign halted       = (state == ST_HALT);
    assign alu.save     = (state == ST_EXEC) && ir[ST_BIT];

    // Host program loads land only while the sequencer is parked
    always_ff @(posedge clk) begin
        if (prog_we && idle_or_halt) begin
            prog[prog_addr] <= prog_data;
        end
    end

    // Register-file write port: writeback in WB, otherwise a host preload while parked
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = rf_addr;
        rf_wr_data = rf_data;
        if (state == ST_WB) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = ir[RD_HI:RD_LO];
            rf_wr_data = alu.alu_out;
        end else if (idle_or_halt && rf_we) begin
            rf_wr_en   = 1'b1;
        end
    end

    fdu_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_wr_en),
        .wr_addr  (rf_wr_addr),
        .wr_data  (rf_wr_data),
        .rd_addr1 (ir[RS1_HI:RS1_LO]),
        .rd_addr2 (ir[RS2_HI:RS2_LO]),
        .rd_data1 (rs1_val),
        .rd_data2 (rs2_val)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a HALT word is recognised at DECODE, start only acts when parked
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: next_state = (ir == HALT_WORD) ? ST_HALT : ST_EXEC;
            ST_EXEC:   next_state = ST_WB;
            ST_WB:     next_state = ST_FETCH;
            ST_HALT:   if (start) next_state = ST_FETCH;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath registers: instruction fetch, operand latch, carry capture and PC advance
    always_ff @(posedge clk) begin
        if (reset) begin
            ir         <= '0;
            pc         <= '0;
            alu.a      <= '0;
            alu.b      <= '0;
            alu.opcode <= OP_ADD;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) pc <= '0;
                end
                ST_FETCH: begin
                    ir <= prog[pc];
                end
                ST_DECODE: begin
                    if (ir != HALT_WORD) begin
                        alu.a      <= rs1_val;
                        alu.b      <= rs2_val;
                        alu.opcode <= ir[OPC_HI:OPC_LO];
                    end
                end
                ST_WB: begin
                    carry_flag <= alu.carry_out;
                    pc         <= pc + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: a table of single-instruction
// programs with hand-computed results, plus directed multi-cycle sequences.
module tb_fetch_decode_unit;
    import cpu8_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        rf_we;
    logic [1:0]  rf_addr;
    logic [7:0]  rf_data;
    logic [3:0]  pc;
    logic        carry_flag;
    logic        busy;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_decode_unit_if alu_bus ();

    fetch_decode_unit #(.PROG_DEPTH(16), .PC_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .alu        (alu_bus),
        .pc         (pc),
        .carry_flag (carry_flag),
        .busy       (busy),
        .halted     (halted)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream combinational ALU stand-in
    logic [8:0]  sum9;
    logic [15:0] prod16;
    always_comb begin
        sum9 = '0;
        prod16 = '0;
        alu_bus.alu_out = '0;
        alu_bus.carry_out = 1'b0;
        case (alu_bus.opcode)
            OP_ADD: begin
                sum9 = {1'b0, alu_bus.a} + {1'b0, alu_bus.b};
                alu_bus.alu_out = sum9[7:0];
                alu_bus.carry_out = sum9[8];
            end
            OP_SUB: begin
                sum9 = {1'b0, alu_bus.a} - {1'b0, alu_bus.b};
                alu_bus.alu_out = sum9[7:0];
                alu_bus.carry_out = sum9[8];
            end
            OP_AND: alu_bus.alu_out = alu_bus.a & alu_bus.b;
            OP_OR:  alu_bus.alu_out = alu_bus.a | alu_bus.b;
            OP_XOR: alu_bus.alu_out = alu_bus.a ^ alu_bus.b;
            OP_MUL: begin
                prod16 = {8'h00, alu_bus.a} * {8'h00, alu_bus.b};
                alu_bus.alu_out = prod16[7:0];
                alu_bus.carry_out = |prod16[15:8];
            end
            OP_DIV: alu_bus.alu_out = (alu_bus.b == 8'h00) ? 8'hFF : alu_bus.a / alu_bus.b;
            default: begin
                alu_bus.alu_out = (alu_bus.a > alu_bus.b) ? 8'h01 : 8'h00;
                alu_bus.carry_out = (alu_bus.a == alu_bus.b);
            end
        endcase
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic       st;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_res;
        logic       exp_c;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input logic st);
        return {op, rd, rs1, rs2, st, 6'b000000};
    endfunction

    function automatic logic [7:0] get_reg(input logic [1:0] idx);
        return dut.u_regfile.regs[idx];
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic load_prog(input logic [3:0] addr, input logic [15:0] data);
        prog_we = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step(1);
        prog_we = 1'b0;
    endtask

    task automatic preload(input logic [1:0] idx, input logic [7:0] val);
        rf_we = 1'b1;
        rf_addr = idx;
        rf_data = val;
        step(1);
        rf_we = 1'b0;
    endtask

    task automatic apply_stimulus();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // One table entry: single instruction followed by HALT
    task automatic run_vector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        do_reset();
        preload(2'd1, v.r1);
        preload(2'd2, v.r2);
        load_prog(4'd0, enc(v.op, v.rd, v.rs1, v.rs2, v.st));
        load_prog(4'd1, HALT_WORD);
        apply_stimulus();
        step(2);
        check_output({tag, "_a"}, 16'(alu_bus.a), 16'(v.exp_a));
        check_output({tag, "_b"}, 16'(alu_bus.b), 16'(v.exp_b));
        check_output({tag, "_opcode"}, 16'(alu_bus.opcode), 16'(v.op));
        check_output({tag, "_save"}, 16'(alu_bus.save), 16'(v.st));
        step(2);
        check_output({tag, "_result"}, 16'(get_reg(v.rd)), 16'(v.exp_res));
        check_output({tag, "_carry"}, 16'(carry_flag), 16'(v.exp_c));
        step(2);
        check_output({tag, "_halted"}, 16'(halted), 16'h1);
        check_output({tag, "_pc"}, 16'(pc), 16'h1);
        check_output({tag, "_save_halt"}, 16'(alu_bus.save), 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        rf_we = 1'b0;
        rf_addr = '0;
        rf_data = '0;

        //          op       rd    rs1   rs2   st    r1     r2     a      b      res    c
        vecs[0]  = '{OP_ADD,  2'd0, 2'd1, 2'd2, 1'b1, 8'd5,  8'd3,  8'd5,  8'd3,  8'd8,  1'b0};
        vecs[1]  = '{OP_SUB,  2'd0, 2'd1, 2'd2, 1'b0, 8'd10, 8'd3,  8'd10, 8'd3,  8'd7,  1'b0};
        vecs[2]  = '{OP_AND,  2'd3, 2'd1, 2'd2, 1'b1, 8'hF0, 8'h3C, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[3]  = '{OP_OR,   2'd2, 2'd1, 2'd2, 1'b0, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[4]  = '{OP_XOR,  2'd0, 2'd1, 2'd2, 1'b1, 8'hAA, 8'h0F, 8'hAA, 8'h0F, 8'hA5, 1'b0};
        vecs[5]  = '{OP_MUL,  2'd0, 2'd1, 2'd2, 1'b1, 8'd200,8'd2,  8'd200,8'd2,  8'h90, 1'b1};
        vecs[6]  = '{OP_DIV,  2'd0, 2'd1, 2'd2, 1'b0, 8'd100,8'd7,  8'd100,8'd7,  8'd14, 1'b0};
        vecs[7]  = '{OP_COMP, 2'd0, 2'd1, 2'd2, 1'b1, 8'd9,  8'd4,  8'd9,  8'd4,  8'd1,  1'b0};
        vecs[8]  = '{OP_ADD,  2'd0, 2'd1, 2'd2, 1'b0, 8'd200,8'd100,8'd200,8'd100,8'h2C, 1'b1};
        vecs[9]  = '{OP_ADD,  2'd1, 2'd1, 2'd1, 1'b1, 8'd7,  8'd0,  8'd7,  8'd7,  8'd14, 1'b0};
        vecs[10] = '{OP_SUB,  2'd0, 2'd1, 2'd2, 1'b0, 8'd3,  8'd5,  8'd3,  8'd5,  8'hFE, 1'b1};

        step(1);
        do_reset();
        check_output("rst_pc", 16'(pc), 16'h0);
        check_output("rst_busy", 16'(busy), 16'h0);
        check_output("rst_halted", 16'(halted), 16'h0);
        check_output("rst_save", 16'(alu_bus.save), 16'h0);
        check_output("rst_carry", 16'(carry_flag), 16'h0);
        check_output("rst_a", 16'(alu_bus.a), 16'h0);
        check_output("rst_opcode", 16'(alu_bus.opcode), 16'h0);

        foreach (vecs[i]) run_vector(i, vecs[i]);

        // Reset arriving in EXEC of an ADD aborts it with no writeback
        do_reset();
        preload(2'd1, 8'd5);
        preload(2'd2, 8'd3);
        load_prog(4'd0, enc(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1));
        load_prog(4'd1, HALT_WORD);
        apply_stimulus();
        step(2);
        check_output("midexec_save_before", 16'(alu_bus.save), 16'h1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_output("midexec_busy", 16'(busy), 16'h0);
        check_output("midexec_halted", 16'(halted), 16'h0);
        check_output("midexec_save", 16'(alu_bus.save), 16'h0);
        check_output("midexec_pc", 16'(pc), 16'h0);
        check_output("midexec_a", 16'(alu_bus.a), 16'h0);
        step(2);
        check_output("midexec_r0", 16'(get_reg(2'd0)), 16'h0);
        check_output("midexec_idle", 16'(busy), 16'h0);

        // Dependent chain: second instruction consumes the first result
        do_reset();
        preload(2'd1, 8'd5);
        preload(2'd2, 8'd3);
        load_prog(4'd0, enc(OP_SUB, 2'd3, 2'd1, 2'd2, 1'b0));
        load_prog(4'd1, enc(OP_XOR, 2'd3, 2'd3, 2'd1, 1'b0));
        load_prog(4'd2, HALT_WORD);
        apply_stimulus();
        step(4);
        check_output("chain_r3_first", 16'(get_reg(2'd3)), 16'h2);
        step(2);
        check_output("chain_a", 16'(alu_bus.a), 16'h2);
        check_output("chain_b", 16'(alu_bus.b), 16'h5);
        check_output("chain_opcode", 16'(alu_bus.opcode), 16'(OP_XOR));
        step(4);
        check_output("chain_halted", 16'(halted), 16'h1);
        check_output("chain_r3_final", 16'(get_reg(2'd3)), 16'h7);
        check_output("chain_pc", 16'(pc), 16'h2);

        // Preload and start in the same IDLE cycle
        do_reset();
        preload(2'd1, 8'd5);
        load_prog(4'd0, enc(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1));
        load_prog(4'd1, HALT_WORD);
        rf_we = 1'b1;
        rf_addr = 2'd2;
        rf_data = 8'd3;
        start = 1'b1;
        step(1);
        rf_we = 1'b0;
        start = 1'b0;
        check_output("simul_busy", 16'(busy), 16'h1);
        step(2);
        check_output("simul_a", 16'(alu_bus.a), 16'h5);
        check_output("simul_b", 16'(alu_bus.b), 16'h3);
        step(4);
        check_output("simul_halted", 16'(halted), 16'h1);
        check_output("simul_r0", 16'(get_reg(2'd0)), 16'h8);

        // Host writes and start while busy are ignored; start in HALT restarts at 0
        apply_stimulus();
        check_output("busyw_restart_pc", 16'(pc), 16'h0);
        prog_we = 1'b1;
        prog_addr = 4'd1;
        prog_data = enc(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0);
        rf_we = 1'b1;
        rf_addr = 2'd2;
        rf_data = 8'd99;
        start = 1'b1;
        step(6);
        prog_we = 1'b0;
        rf_we = 1'b0;
        start = 1'b0;
        check_output("busyw_halted", 16'(halted), 16'h1);
        check_output("busyw_pc", 16'(pc), 16'h1);
        check_output("busyw_r2", 16'(get_reg(2'd2)), 16'h3);
        check_output("busyw_r0", 16'(get_reg(2'd0)), 16'h8);
        apply_stimulus();
        check_output("halt_restart_pc", 16'(pc), 16'h0);
        check_output("halt_restart_busy", 16'(busy), 16'h1);
        check_output("halt_restart_halted", 16'(halted), 16'h0);
        step(6);
        check_output("busyw_prog_kept", 16'(halted), 16'h1);
        check_output("busyw_pc2", 16'(pc), 16'h1);

        // Carry captured at MUL writeback, cleared by the next carry-free result
        do_reset();
        preload(2'd1, 8'd200);
        preload(2'd2, 8'd2);
        load_prog(4'd0, enc(OP_MUL, 2'd0, 2'd1, 2'd2, 1'b1));
        load_prog(4'd1, enc(OP_AND, 2'd3, 2'd1, 2'd2, 1'b0));
        load_prog(4'd2, HALT_WORD);
        apply_stimulus();
        step(4);
        check_output("carry_set", 16'(carry_flag), 16'h1);
        check_output("carry_mul_r0", 16'(get_reg(2'd0)), 16'h90);
        step(4);
        check_output("carry_clear", 16'(carry_flag), 16'h0);
        check_output("carry_and_r3", 16'(get_reg(2'd3)), 16'h0);
        step(2);
        check_output("carry_halted", 16'(halted), 16'h1);
        check_output("carry_pc", 16'(pc), 16'h2);

        // No HALT word anywhere: pc wraps 15 -> 0 and execution keeps going
        do_reset();
        preload(2'd2, 8'd1);
        for (int i = 0; i < 16; i++) begin
            load_prog(4'(i), enc(OP_ADD, 2'd1, 2'd1, 2'd2, 1'b0));
        end
        apply_stimulus();
        step(60);
        check_output("wrap_pc15", 16'(pc), 16'hF);
        check_output("wrap_r1_15", 16'(get_reg(2'd1)), 16'hF);
        step(4);
        check_output("wrap_pc0", 16'(pc), 16'h0);
        check_output("wrap_busy", 16'(busy), 16'h1);
        check_output("wrap_r1_16", 16'(get_reg(2'd1)), 16'h10);
        step(4);
        check_output("wrap_pc1", 16'(pc), 16'h1);
        check_output("wrap_r1_17", 16'(get_reg(2'd1)), 16'h11);
        do_reset();
        check_output("final_rst_busy", 16'(busy), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
